// File: rtl/axi_arbiter.sv
// axi_arbiter: two-master (IFU read-only, LSU read/write) to one AXI4-Lite port arbiter, one transaction in flight.
// Optional feature macro AXI_ARB_ROUND_ROBIN_EN: round-robin tie-break between IFU and LSU (default: fixed LSU-first).
module axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ifu_arvalid,
  input  logic                ifu_rready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  output logic [1:0]          ifu_rresp,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_arvalid,
  input  logic                lsu_rready,
  input  logic                lsu_awvalid,
  input  logic                lsu_wvalid,
  input  logic                lsu_bready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic                lsu_awready,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_rresp,
  output logic [1:0]          lsu_bresp,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                arvalid,
  output logic                rready,
  output logic                awvalid,
  output logic                wvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                arready,
  input  logic                rvalid,
  input  logic                awready,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          rresp,
  input  logic [1:0]          bresp,
  input  logic [DATA_W-1:0]   rdata
);
  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;
  state_e state_q, state_d;
  logic lsu_wr_req, lsu_req, ifu_wins;
  assign lsu_wr_req = lsu_awvalid | lsu_wvalid;
  assign lsu_req    = lsu_wr_req | lsu_arvalid;
`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
  assign ifu_wins = ifu_arvalid & (~lsu_req | last_grant_q);
  // record the winner of each IDLE grant (1 = LSU) so the other master wins the next tie
  always_comb last_grant_d = (state_q == IDLE && state_d != IDLE) ? (state_d != IFU_RD) : last_grant_q;
  // last-grant register, LSU after reset so the first tie goes to the IFU
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) last_grant_q <= 1'b1;
    else last_grant_q <= last_grant_d;
`else
  assign ifu_wins = ifu_arvalid & ~lsu_req;
`endif
  // grant state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // arbitrate in IDLE, return to IDLE on the owner's response handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ifu_wins ? IFU_RD : lsu_wr_req ? LSU_WR : lsu_arvalid ? LSU_RD : IDLE;
      IFU_RD:  if (rvalid & ifu_rready) state_d = IDLE;
      LSU_RD:  if (rvalid & lsu_rready) state_d = IDLE;
      LSU_WR:  if (bvalid & lsu_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // route the owner's channels to the crossbar; everything else, and all of IDLE, stays 0
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rresp   = '0;
    ifu_rdata   = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_rresp   = '0;
    lsu_bresp   = '0;
    lsu_rdata   = '0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    araddr      = '0;
    awaddr      = '0;
    wdata       = '0;
    wstrb       = '0;
    case (state_q)
      IFU_RD: begin
        arvalid     = ifu_arvalid;
        araddr      = ifu_araddr;
        rready      = ifu_rready;
        ifu_arready = arready;
        ifu_rvalid  = rvalid;
        ifu_rresp   = rresp;
        ifu_rdata   = rdata;
      end
      LSU_RD: begin
        arvalid     = lsu_arvalid;
        araddr      = lsu_araddr;
        rready      = lsu_rready;
        lsu_arready = arready;
        lsu_rvalid  = rvalid;
        lsu_rresp   = rresp;
        lsu_rdata   = rdata;
      end
      LSU_WR: begin
        awvalid     = lsu_awvalid;
        awaddr      = lsu_awaddr;
        wvalid      = lsu_wvalid;
        wdata       = lsu_wdata;
        wstrb       = lsu_wstrb;
        bready      = lsu_bready;
        lsu_awready = awready;
        lsu_wready  = wready;
        lsu_bvalid  = bvalid;
        lsu_bresp   = bresp;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: directed scoreboard bench for axi_arbiter with a small AXI4-Lite slave model.
module tb_axi_arbiter;
  typedef struct packed {logic [1:0] resp; logic [31:0] data;} rsp_t;
  logic clock = 1'b0, reset_n = 1'b0;
  logic ifu_arvalid = 0, ifu_rready = 0;
  logic [31:0] ifu_araddr = 0;
  logic ifu_arready, ifu_rvalid;
  logic [1:0] ifu_rresp;
  logic [31:0] ifu_rdata;
  logic lsu_arvalid = 0, lsu_rready = 0, lsu_awvalid = 0, lsu_wvalid = 0, lsu_bready = 0;
  logic [31:0] lsu_araddr = 0, lsu_awaddr = 0, lsu_wdata = 0;
  logic [3:0] lsu_wstrb = 0;
  logic lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
  logic [1:0] lsu_rresp, lsu_bresp;
  logic [31:0] lsu_rdata;
  logic arvalid, rready, awvalid, wvalid, bready;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0] wstrb;
  logic s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [1:0] s_rresp;
  logic [1:0] s_bresp = 2'b00;
  logic [31:0] s_rdata;
  logic [1:0] slv_rresp = 2'b00;
  logic rd_pend, rd_cnt, got_aw, got_w;
  logic [31:0] rd_addr, w_addr, w_data;
  logic [3:0] w_strb;
  logic any_out, ifu_any, lsu_any;
  int total = 0, bad = 0, cyc = 0;
  int ifu_first = -1, lsu_first = -1, ifu_r_cyc = 0, lsu_r_cyc = 0;
  logic snap_arvalid, snap_lsu_rvalid, ifu_dirty;
  logic [31:0] snap_araddr;
  rsp_t ifu_q[$], lsu_rq[$];
  logic [1:0] lsu_bq[$];
  logic grant_log[$], exp_log[$];

  axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .ifu_arvalid(ifu_arvalid), .ifu_rready(ifu_rready), .ifu_araddr(ifu_araddr),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata),
    .lsu_arvalid(lsu_arvalid), .lsu_rready(lsu_rready), .lsu_awvalid(lsu_awvalid),
    .lsu_wvalid(lsu_wvalid), .lsu_bready(lsu_bready), .lsu_araddr(lsu_araddr),
    .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_awready(lsu_awready),
    .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_rresp(lsu_rresp),
    .lsu_bresp(lsu_bresp), .lsu_rdata(lsu_rdata),
    .arvalid(arvalid), .rready(rready), .awvalid(awvalid), .wvalid(wvalid), .bready(bready),
    .araddr(araddr), .awaddr(awaddr), .wdata(wdata), .wstrb(wstrb),
    .arready(s_arready), .rvalid(s_rvalid), .awready(s_awready), .wready(s_wready),
    .bvalid(s_bvalid), .rresp(s_rresp), .bresp(s_bresp), .rdata(s_rdata)
  );

  always #5 clock = ~clock;

  assign ifu_any = |{ifu_arready, ifu_rvalid, ifu_rresp, ifu_rdata};
  assign lsu_any = |{lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid, lsu_rresp, lsu_bresp, lsu_rdata};
  assign any_out = ifu_any | lsu_any | (|{arvalid, rready, awvalid, wvalid, bready, araddr, awaddr, wdata, wstrb});

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h3000_0000) ? 32'h0000_0413 : a ^ 32'h5A5A_5A5A;
  endfunction

  assign s_arready = !rd_pend && !s_rvalid;
  assign s_wready  = !got_w && !s_bvalid;
  assign s_awready = got_w && !got_aw && !s_bvalid;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rd_pend <= 0; rd_cnt <= 0; rd_addr <= 0; s_rvalid <= 0; s_rdata <= 0; s_rresp <= 0;
      got_aw <= 0; got_w <= 0; s_bvalid <= 0; w_addr <= 0; w_data <= 0; w_strb <= 0;
    end else begin
      if (arvalid && s_arready) begin
        rd_pend <= 1; rd_cnt <= 1; rd_addr <= araddr;
      end else if (rd_pend) begin
        if (rd_cnt) rd_cnt <= 0;
        else begin
          rd_pend <= 0; s_rvalid <= 1; s_rdata <= rd_fn(rd_addr); s_rresp <= slv_rresp;
        end
      end
      if (s_rvalid && rready) s_rvalid <= 0;
      if (wvalid && s_wready) begin
        got_w <= 1; w_data <= wdata; w_strb <= wstrb;
      end
      if (awvalid && s_awready) begin
        got_aw <= 1; w_addr <= awaddr;
      end
      if (got_w && got_aw) begin
        got_w <= 0; got_aw <= 0; s_bvalid <= 1;
      end
      if (s_bvalid && bready) s_bvalid <= 0;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit done();
    return ifu_q.size() == 0 && lsu_rq.size() == 0 && lsu_bq.size() == 0 &&
           !ifu_arvalid && !lsu_arvalid && !lsu_awvalid && !lsu_wvalid;
  endfunction

  task automatic step();
    logic iar, lar, law, lw;
    rsp_t e;
    logic [1:0] b;
    @(negedge clock);
    cyc++;
    chk("one_owner", 64'(ifu_any & lsu_any), 64'd0);
    if (lsu_bq.size() != 0 && ifu_any) ifu_dirty = 1'b1;
    snap_arvalid = arvalid;
    snap_araddr = araddr;
    snap_lsu_rvalid = lsu_rvalid;
    iar = ifu_arvalid & ifu_arready;
    lar = lsu_arvalid & lsu_arready;
    law = lsu_awvalid & lsu_awready;
    lw  = lsu_wvalid & lsu_wready;
    if (ifu_arready && ifu_first < 0) ifu_first = cyc;
    if ((lsu_arready || lsu_awready || lsu_wready) && lsu_first < 0) lsu_first = cyc;
    if (ifu_rvalid && ifu_rready) begin
      ifu_r_cyc = cyc;
      grant_log.push_back(1'b0);
      if (ifu_q.size() == 0) chk("ifu_unexpected_r", 64'd1, 64'd0);
      else begin
        e = ifu_q.pop_front();
        chk("ifu_rdata", 64'(ifu_rdata), 64'(e.data));
        chk("ifu_rresp", 64'(ifu_rresp), 64'(e.resp));
      end
    end
    if (lsu_rvalid && lsu_rready) begin
      lsu_r_cyc = cyc;
      grant_log.push_back(1'b1);
      if (lsu_rq.size() == 0) chk("lsu_unexpected_r", 64'd1, 64'd0);
      else begin
        e = lsu_rq.pop_front();
        chk("lsu_rdata", 64'(lsu_rdata), 64'(e.data));
        chk("lsu_rresp", 64'(lsu_rresp), 64'(e.resp));
      end
    end
    if (lsu_bvalid && lsu_bready) begin
      grant_log.push_back(1'b1);
      if (lsu_bq.size() == 0) chk("lsu_unexpected_b", 64'd1, 64'd0);
      else begin
        b = lsu_bq.pop_front();
        chk("lsu_bresp", 64'(lsu_bresp), 64'(b));
      end
    end
    @(posedge clock);
    #1;
    if (iar) ifu_arvalid = 0;
    if (lar) lsu_arvalid = 0;
    if (law) lsu_awvalid = 0;
    if (lw)  lsu_wvalid = 0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done() && n < max) begin
      step();
      n++;
    end
    chk("complete_in_budget", 64'(done()), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    chk(tag, 64'(any_out), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic ifu_read(input logic [31:0] a, input logic [1:0] resp);
    ifu_araddr = a;
    ifu_q.push_back({resp, rd_fn(a)});
    ifu_first = -1;
    ifu_arvalid = 1;
  endtask

  task automatic lsu_read(input logic [31:0] a, input logic [1:0] resp);
    lsu_araddr = a;
    lsu_rq.push_back({resp, rd_fn(a)});
    lsu_first = -1;
    lsu_arvalid = 1;
  endtask

  initial begin
    ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", 64'(any_out), 64'd0);
    reset_n = 1;
    check_idle("idle_after_reset");

    ifu_araddr = 32'h3000_0000;
    ifu_q.push_back({2'b00, 32'h0000_0413});
    ifu_arvalid = 1;
    @(negedge clock);
    chk("arb_latency_idle", 64'(arvalid), 64'd0);
    @(posedge clock);
    #1;
    step();
    chk("arb_latency_fwd", 64'(snap_arvalid), 64'd1);
    chk("ifu_araddr_fwd", 64'(snap_araddr), 64'h3000_0000);
    wait_done(50);
    check_idle("idle_after_ifu");

    ifu_dirty = 0;
    lsu_awaddr = 32'h8000_0010; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
    lsu_bq.push_back(2'b00);
    lsu_awvalid = 1; lsu_wvalid = 1;
    wait_done(50);
    chk("slave_awaddr", 64'(w_addr), 64'h8000_0010);
    chk("slave_wdata", 64'(w_data), 64'hDEAD_BEEF);
    chk("slave_wstrb", 64'(w_strb), 64'hF);
    chk("ifu_quiet_during_write", 64'(ifu_dirty), 64'd0);

    grant_log.delete();
    for (int r = 0; r < 4; r++) begin
      ifu_read(32'h3000_0100 + 32'(r * 4), 2'b00);
      lsu_read(32'h9000_0000 + 32'(r * 4), 2'b00);
`ifdef AXI_ARB_ROUND_ROBIN_EN
      exp_log.push_back(1'b0); exp_log.push_back(1'b1);
`else
      exp_log.push_back(1'b1); exp_log.push_back(1'b0);
`endif
      wait_done(100);
`ifdef AXI_ARB_ROUND_ROBIN_EN
      chk("second_grant_gap", 64'(lsu_first - ifu_r_cyc), 64'd2);
`else
      chk("second_grant_gap", 64'(ifu_first - lsu_r_cyc), 64'd2);
`endif
    end
    chk("grant_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk($sformatf("grant_order[%0d]", i), 64'(grant_log[i]), 64'(exp_log[i]));

    lsu_rready = 0;
    lsu_read(32'h0000_0010, 2'b00);
    for (int n = 0; n < 20 && !snap_lsu_rvalid; n++) step();
    chk("rvalid_pending_before_reset", 64'(lsu_rvalid), 64'd1);
    #1 reset_n = 0;
    #1 chk("outputs_zero_in_reset", 64'(any_out), 64'd0);
    lsu_rq.delete();
    lsu_rready = 1;
    @(posedge clock);
    #1 reset_n = 1;
    check_idle("idle_after_midreset");
    ifu_read(32'h3000_0000, 2'b00);
    wait_done(50);

    slv_rresp = 2'b10;
    lsu_read(32'h0000_0040, 2'b10);
    wait_done(50);
    slv_rresp = 2'b00;
    check_idle("idle_after_slverr");
    ifu_read(32'h0000_0080, 2'b00);
    wait_done(50);
    check_idle("idle_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
